// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-writer counters with decode hazard flags
// Counts in-flight writers per architectural register; x0 is never tracked.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            issue_valid,
  input  logic [4:0]      issue_dst,
  input  logic            retire_valid,
  input  logic [4:0]      retire_dst,
  input  logic [1:0]      kill_valid,
  input  logic [4:0]      kill_dst0,
  input  logic [4:0]      kill_dst1,
  output logic            bubble1,
  output logic            bubble2,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] SMAX = $signed(SW'((1 << CNT_W) - 1));

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;

  function automatic logic [1:0] dec_of(input logic [4:0] idx);
    logic [1:0] d;
    d = {1'b0, retire_valid && (retire_dst == idx)}
      + {1'b0, kill_valid[0] && (kill_dst0 == idx)}
      + {1'b0, kill_valid[1] && (kill_dst1 == idx)};
    return (idx == 5'd0) ? 2'd0 : d;
  endfunction

  // Same-cycle release: retires and kills are subtracted, the issue is not.
  function automatic logic pending(input logic [4:0] idx);
    logic signed [SW-1:0] diff;
    if (idx == 5'd0 || int'(idx) >= NREG) return 1'b0;
    diff = $signed({2'b00, cnt_q[idx]}) - $signed({{(SW-2){1'b0}}, dec_of(idx)});
    return diff != '0;
  endfunction

  always_comb begin
    logic signed [SW-1:0] sum;
    logic                 inc;
    logic [4:0]           idx;
    sum      = '0;
    inc      = 1'b0;
    idx      = '0;
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      idx = 5'(i);
      inc = issue_valid && (issue_dst == idx);
      sum = $signed({2'b00, cnt_q[i]})
          + $signed({{(SW-1){1'b0}}, inc})
          - $signed({{(SW-2){1'b0}}, dec_of(idx)});
      if (sum < 0) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else if (sum > SMAX) begin
        cnt_d[i] = '1;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) busy_vec[i] = (cnt_q[i] != '0);
  end

  // Gated by reset so that decrements on the inputs cannot raise a flag while held.
  always_comb begin
    bubble1 = resetn && pending(rs1);
    bubble2 = resetn && pending(rs2);
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed vector bench for reg_scoreboard
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs1, rs2, issue_dst, retire_dst, kill_dst0, kill_dst1;
  logic        issue_valid, retire_valid;
  logic [1:0]  kill_valid;
  logic        bubble1, bubble2, err;
  logic [31:0] busy_vec;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .retire_valid(retire_valid), .retire_dst(retire_dst),
    .kill_valid(kill_valid), .kill_dst0(kill_dst0), .kill_dst1(kill_dst1),
    .bubble1(bubble1), .bubble2(bubble2), .busy_vec(busy_vec), .err(err)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        iv;
    logic [4:0]  idst;
    logic        rv;
    logic [4:0]  rdst;
    logic [1:0]  kv;
    logic [4:0]  k0, k1;
    logic        b1, b2;
    logic [31:0] busy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2,
                              input logic iv, input logic [4:0] idst,
                              input logic rv, input logic [4:0] rdst,
                              input logic [1:0] kv, input logic [4:0] k0, input logic [4:0] k1,
                              input logic b1, input logic b2, input logic [31:0] busy,
                              input logic e);
    vec_t v;
    v.rs1 = r1; v.rs2 = r2; v.iv = iv; v.idst = idst; v.rv = rv; v.rdst = rdst;
    v.kv = kv; v.k0 = k0; v.k1 = k1; v.b1 = b1; v.b2 = b2; v.busy = busy; v.err = e;
    return v;
  endfunction

  function automatic logic [31:0] bit_of(input int i);
    return 32'h1 << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2;
    issue_valid = v.iv; issue_dst = v.idst;
    retire_valid = v.rv; retire_dst = v.rdst;
    kill_valid = v.kv; kill_dst0 = v.k0; kill_dst1 = v.k1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    check({tag, " bubble1"}, 32'(bubble1), 32'(v.b1));
    check({tag, " bubble2"}, 32'(bubble2), 32'(v.b2));
    check({tag, " busy_vec"}, busy_vec, v.busy);
    check({tag, " err"}, 32'(err), 32'(v.err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      issue_valid = 1'($urandom); issue_dst = 5'($urandom);
      retire_valid = 1'($urandom); retire_dst = 5'($urandom);
      kill_valid = 2'($urandom); kill_dst0 = 5'($urandom); kill_dst1 = 5'($urandom);
      #2;
      check($sformatf("reset%0d bubble1", c), 32'(bubble1), 32'd0);
      check($sformatf("reset%0d bubble2", c), 32'(bubble2), 32'd0);
      check($sformatf("reset%0d busy_vec", c), busy_vec, 32'd0);
      check($sformatf("reset%0d err", c), 32'(err), 32'd0);
    end
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;

    // issue x5, retire x5 three cycles later
    vecs.push_back(mk(5, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 6, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 6, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(5), 0));
    vecs.push_back(mk(5, 6, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(5), 0));
    vecs.push_back(mk(5, 6, 0, 0, 1, 5, 2'b00, 0, 0, 0, 0, bit_of(5), 0));
    vecs.push_back(mk(5, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // simultaneous issue and retire on x10 nets to zero
    vecs.push_back(mk(10, 0, 1, 10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(10, 0, 1, 10, 1, 10, 2'b00, 0, 0, 0, 0, bit_of(10), 0));
    vecs.push_back(mk(10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(10), 0));
    vecs.push_back(mk(10, 0, 0, 0, 1, 10, 2'b00, 0, 0, 0, 0, bit_of(10), 0));
    vecs.push_back(mk(10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // retire and kill0 on the same register are two decrements
    vecs.push_back(mk(12, 0, 1, 12, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12, 0, 1, 12, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(12), 0));
    vecs.push_back(mk(12, 0, 0, 0, 1, 12, 2'b01, 12, 0, 0, 0, bit_of(12), 0));
    vecs.push_back(mk(12, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // four issues to x7 saturate at 3, then three retires drain it
    vecs.push_back(mk(0, 7, 1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 1, 7, 0, 0, 2'b00, 0, 0, 0, 1, bit_of(7), 0));
    vecs.push_back(mk(0, 7, 1, 7, 0, 0, 2'b00, 0, 0, 0, 1, bit_of(7), 0));
    vecs.push_back(mk(0, 7, 1, 7, 0, 0, 2'b00, 0, 0, 0, 1, bit_of(7), 0));
    vecs.push_back(mk(0, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, bit_of(7), 1));
    vecs.push_back(mk(0, 7, 0, 0, 1, 7, 2'b00, 0, 0, 0, 1, bit_of(7), 1));
    vecs.push_back(mk(0, 7, 0, 0, 1, 7, 2'b00, 0, 0, 0, 1, bit_of(7), 1));
    vecs.push_back(mk(0, 7, 0, 0, 1, 7, 2'b00, 0, 0, 0, 0, bit_of(7), 1));
    vecs.push_back(mk(0, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // flush kills both x3 writers in one cycle
    do_reset();
    apply(mk(3, 0, 1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "flush0");
    apply(mk(3, 0, 1, 3, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(3), 0), "flush1");
    apply(mk(3, 0, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, bit_of(3), 0), "flush2");
    apply(mk(3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "flush3");

    // x0 traffic is ignored
    apply(mk(0, 0, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0), "x0_a");
    apply(mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "x0_b");
    apply(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "x0_c");

    // issue, retire and two kills on x11 nets -2 from a count of 1
    apply(mk(11, 0, 1, 11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "net2_a");
    apply(mk(0, 0, 1, 11, 1, 11, 2'b11, 11, 11, 0, 0, bit_of(11), 0), "net2_b");
    apply(mk(11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "net2_c");

    // underflow, then reset in the middle of a cycle
    do_reset();
    apply(mk(0, 0, 0, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0), "udf_a");
    apply(mk(9, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "udf_b");
    apply(mk(4, 8, 1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "udf_c");
    apply(mk(4, 8, 1, 8, 0, 0, 2'b00, 0, 0, 1, 0, bit_of(4), 1), "udf_d");
    apply(mk(4, 8, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, bit_of(4) | bit_of(8), 1), "udf_e");
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst bubble1", 32'(bubble1), 32'd0);
    check("midrst bubble2", 32'(bubble2), 32'd0);
    check("midrst busy_vec", busy_vec, 32'd0);
    check("midrst err", 32'(err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    apply(mk(4, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "postrst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
